// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: entry layout, default depth,
// address width and the all-ones SRAM mask.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    // Entries carry SB_AW address bits; the top's AW must not exceed this.
    localparam int SB_AW = 14;
    localparam logic [31:0] SB_MASK_ONES = '1;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [31:0]      bweb;
        logic [31:0]      data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue. Exposes every slot plus a valid vector so the top can
// compare all pending addresses against the current load in parallel.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  sb_entry_t             wr_i,
    output sb_entry_t [DEPTH-1:0] ent_o,
    output logic [DEPTH-1:0]      vld_o,
    output logic [PW-1:0]         head_o,
    output logic [PW:0]           cnt_o,
    output logic                  full_o,
    output logic                  empty_o
);
    sb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [PW-1:0] off;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign ent_o   = mem_q;
    assign head_o  = head_q;
    assign cnt_o   = cnt_q;

    always_comb begin
        head_d = head_q + PW'(do_pop);
        tail_d = tail_q + PW'(do_push);
        cnt_d  = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // A slot is live when its distance from head is below the count.
    always_comb begin
        off   = '0;
        vld_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head_q;
            vld_o[i] = ({1'b0, off} < cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= wr_i;
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port data SRAM: loads win the port,
// stores drain in load-free cycles. Optional byte forwarding under STORE_FWD_EN.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_re,
    input  logic          cpu_web,
    input  logic [31:0]   cpu_bweb,
    input  logic [AW-1:0] cpu_a,
    input  logic [31:0]   cpu_din,
    output logic [31:0]   cpu_dout,
    output logic          sb_stall,
    output logic          sb_empty,
    output logic          sram_web,
    output logic [31:0]   sram_bweb,
    output logic [AW-1:0] sram_a,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] ent;
    sb_entry_t             wr_ent, head_ent;
    logic [DEPTH-1:0]      vld;
    logic [PW-1:0]         head, idx;
    logic [PW:0]           cnt;
    logic                  full, empty;
    logic                  is_store, push, pop, load_go, stall_load, hit_any;
`ifdef STORE_FWD_EN
    logic                  part_hit;
    logic [3:0]            fwd_mask_d, fwd_mask_q;
    logic [31:0]           fwd_data_d, fwd_data_q;
`endif

    assign wr_ent   = '{addr: SB_AW'(cpu_a), bweb: cpu_bweb, data: cpu_din};
    assign head_ent = ent[head];
    assign sb_empty = empty;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wr_i    (wr_ent),
        .ent_o   (ent),
        .vld_o   (vld),
        .head_o  (head),
        .cnt_o   (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    // Walk oldest to youngest so later matches overwrite earlier forwarded bytes.
    always_comb begin
        hit_any = 1'b0;
        idx     = head;
`ifdef STORE_FWD_EN
        part_hit   = 1'b0;
        fwd_mask_d = '0;
        fwd_data_d = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (vld[idx] && (ent[idx].addr[AW-1:0] == cpu_a)) begin
                hit_any = 1'b1;
`ifdef STORE_FWD_EN
                for (int b = 0; b < 4; b++) begin
                    if (ent[idx].bweb[8*b +: 8] == 8'h00) begin
                        fwd_mask_d[b]          = 1'b1;
                        fwd_data_d[8*b +: 8]   = ent[idx].data[8*b +: 8];
                    end else if (ent[idx].bweb[8*b +: 8] != 8'hFF) begin
                        part_hit = 1'b1;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
`ifdef STORE_FWD_EN
        stall_load = cpu_re && hit_any && part_hit;
`else
        stall_load = cpu_re && hit_any;
`endif
        // A load with a store strobe is treated as a plain load.
        is_store  = !cpu_re && !cpu_web;
        load_go   = cpu_re && !stall_load;
        push      = is_store && !full;
        pop       = !empty && !load_go;
        sb_stall  = stall_load || (is_store && full);
        sram_web  = 1'b1;
        sram_bweb = SB_MASK_ONES;
        sram_a    = cpu_a;
        sram_din  = head_ent.data;
        if (pop) begin
            sram_web  = 1'b0;
            sram_bweb = head_ent.bweb;
            sram_a    = head_ent.addr[AW-1:0];
        end
    end

`ifdef STORE_FWD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_mask_q <= load_go ? fwd_mask_d : 4'b0000;
            fwd_data_q <= fwd_data_d;
        end
    end

    always_comb begin
        cpu_dout = sram_dout;
        for (int b = 0; b < 4; b++)
            if (fwd_mask_q[b]) cpu_dout[8*b +: 8] = fwd_data_q[8*b +: 8];
    end
`else
    assign cpu_dout = sram_dout;
`endif

endmodule
